mem_wb_stage: RTL and testbench

// - MEM/WB back end of the 5-stage RV32 pipeline: byte-addressed data RAM with sized/sign-extended access,
//   MEM/WB pipeline register, write-back source mux, and load-use hazard detection (stall) for the ID stage.
// - Sits between the EX/MEM register and the integer/float register files; not_stall drives PC, IF/ID enables and ID/EX bubble.

---
 rtl/mem_wb_stage_pkg.sv | 48 ++++
 rtl/mem_wb_stage_dmem_byte_ram.sv | 44 ++++
 rtl/mem_wb_stage.sv | 79 +++++++
 tb/tb_mem_wb_stage.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared constants and types for the MEM/WB back end: access-size encodings,
// write-back source selection and the MEM/WB pipeline register layout.
package mem_wb_stage_pkg;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 8;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Select bits are {offset_to_reg, mem_to_reg}
  typedef enum logic [1:0] {
    WB_ALU    = 2'b00,
    WB_LOAD   = 2'b01,
    WB_BRANCH = 2'b10,
    WB_LINK   = 2'b11
  } wb_sel_e;

  typedef struct packed {
    wb_sel_e         sel;
    logic            reg_write;
    logic            freg_write;
    logic [4:0]      rd;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] branch_addr;
    logic [XLEN-1:0] next_pc;
  } memwb_t;

  // Unlisted load encodings fall back to the raw little-endian word
  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3,
                                                  input logic [XLEN-1:0] word);
    case (f3)
      F3_LB:   return {{(XLEN-8){word[7]}}, word[7:0]};
      F3_LH:   return {{(XLEN-16){word[15]}}, word[15:0]};
      F3_LBU:  return {{(XLEN-8){1'b0}}, word[7:0]};
      F3_LHU:  return {{(XLEN-16){1'b0}}, word[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/mem_wb_stage_dmem_byte_ram.sv
// Byte-addressed little-endian data RAM: four wrapping read lanes, sized
// synchronous write. Contents survive clear; only the write is suppressed.
module dmem_byte_ram
  import mem_wb_stage_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [2:0]        func3,
  input  logic              we,
  output logic [XLEN-1:0]   rdata
);

  logic [7:0] mem_q [2**ADDR_W] = '{default: 8'h00};

  // Lane addresses wrap naturally at the address width
  logic [ADDR_W-1:0] a1, a2, a3;
  assign a1 = addr + ADDR_W'(1);
  assign a2 = addr + ADDR_W'(2);
  assign a3 = addr + ADDR_W'(3);

  assign rdata = {mem_q[a3], mem_q[a2], mem_q[a1], mem_q[addr]};

  always_ff @(posedge clock) begin
    if (we && !clear) begin
      case (func3)
        F3_SB: mem_q[addr] <= wdata[7:0];
        F3_SH: begin
          mem_q[addr] <= wdata[7:0];
          mem_q[a1]   <= wdata[15:8];
        end
        F3_SW: begin
          mem_q[addr] <= wdata[7:0];
          mem_q[a1]   <= wdata[15:8];
          mem_q[a2]   <= wdata[23:16];
          mem_q[a3]   <= wdata[31:24];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB back end: data RAM access, MEM/WB pipeline register, write-back mux
// and load-use hazard detection for the ID stage.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input  logic            clock,
  input  logic            clear,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_data_b,
  input  logic [2:0]      mem_func3,
  input  logic            mem_mem_write,
  input  logic            mem_mem_to_reg,
  input  logic            mem_offset_to_reg,
  input  logic            mem_reg_write,
  input  logic            mem_freg_write,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_branch_addr,
  input  logic [XLEN-1:0] mem_next_pc,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  output logic            not_stall,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_reg_write,
  output logic            wb_freg_write
);

  logic [XLEN-1:0] ram_word;
  memwb_t          wb_d, wb_q;

  dmem_byte_ram u_dmem (
    .clock (clock),
    .clear (clear),
    .addr  (mem_alu_result[ADDR_W-1:0]),
    .wdata (mem_data_b),
    .func3 (mem_func3),
    .we    (mem_mem_write),
    .rdata (ram_word)
  );

  always_comb begin
    wb_d             = '0;
    wb_d.sel         = wb_sel_e'({mem_offset_to_reg, mem_mem_to_reg});
    wb_d.reg_write   = mem_reg_write;
    wb_d.freg_write  = mem_freg_write;
    wb_d.rd          = mem_rd;
    wb_d.alu_result  = mem_alu_result;
    wb_d.load_data   = load_extend(mem_func3, ram_word);
    wb_d.branch_addr = mem_branch_addr;
    wb_d.next_pc     = mem_next_pc;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) wb_q <= '0;
    else       wb_q <= wb_d;
  end

  always_comb begin
    wb_data = wb_q.alu_result;
    case (wb_q.sel)
      WB_ALU:    wb_data = wb_q.alu_result;
      WB_LOAD:   wb_data = wb_q.load_data;
      WB_BRANCH: wb_data = wb_q.branch_addr;
      WB_LINK:   wb_data = wb_q.next_pc;
      default:   wb_data = wb_q.alu_result;
    endcase
  end

  assign wb_rd         = wb_q.rd;
  assign wb_reg_write  = wb_q.reg_write;
  assign wb_freg_write = wb_q.freg_write;

  // Stall only when the load in EX writes a real register the ID stage reads
  assign not_stall = ~(ex_mem_read & (ex_rd != 5'd0) &
                       ((ex_rd == id_rs1) | (ex_rd == id_rs2)));

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed load/store, wrap, mux,
// hazard and clear scenarios plus randomized traffic against a byte-array model.
module tb_mem_wb_stage;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] mem_alu_result = '0;
  logic [31:0] mem_data_b = '0;
  logic [2:0]  mem_func3 = '0;
  logic        mem_mem_write = 1'b0;
  logic        mem_mem_to_reg = 1'b0;
  logic        mem_offset_to_reg = 1'b0;
  logic        mem_reg_write = 1'b0;
  logic        mem_freg_write = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_branch_addr = '0;
  logic [31:0] mem_next_pc = '0;
  logic        ex_mem_read = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [4:0]  id_rs1 = '0;
  logic [4:0]  id_rs2 = '0;
  logic        not_stall;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        wb_freg_write;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] ref_mem [256];

  mem_wb_stage dut (
    .clock             (clock),
    .clear             (clear),
    .mem_alu_result    (mem_alu_result),
    .mem_data_b        (mem_data_b),
    .mem_func3         (mem_func3),
    .mem_mem_write     (mem_mem_write),
    .mem_mem_to_reg    (mem_mem_to_reg),
    .mem_offset_to_reg (mem_offset_to_reg),
    .mem_reg_write     (mem_reg_write),
    .mem_freg_write    (mem_freg_write),
    .mem_rd            (mem_rd),
    .mem_branch_addr   (mem_branch_addr),
    .mem_next_pc       (mem_next_pc),
    .ex_mem_read       (ex_mem_read),
    .ex_rd             (ex_rd),
    .id_rs1            (id_rs1),
    .id_rs2            (id_rs2),
    .not_stall         (not_stall),
    .wb_data           (wb_data),
    .wb_rd             (wb_rd),
    .wb_reg_write      (wb_reg_write),
    .wb_freg_write     (wb_freg_write)
  );

  always #5 clock = ~clock;

  // Reference model: plain byte array, sizes taken from the access width
  function automatic logic [31:0] model_load(input int a, input logic [2:0] f3);
    logic [31:0] w;
    w = {ref_mem[(a+3)%256], ref_mem[(a+2)%256], ref_mem[(a+1)%256], ref_mem[a%256]};
    case (f3)
      3'd0:    return (w[7] ? 32'hFFFF_FF00 : 32'h0) | {24'h0, w[7:0]};
      3'd1:    return (w[15] ? 32'hFFFF_0000 : 32'h0) | {16'h0, w[15:0]};
      3'd4:    return w & 32'h0000_00FF;
      3'd5:    return w & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  task automatic model_store(input int a, input logic [2:0] f3, input logic [31:0] d);
    int n;
    n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
    for (int i = 0; i < n; i++) ref_mem[(a+i)%256] = d[8*i +: 8];
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drives one MEM-stage op, updates the model and returns the expected wb_data
  task automatic do_op(input logic [31:0] alu, input logic [31:0] data,
                       input logic [2:0] f3, input logic we, input logic m2r,
                       input logic o2r, input logic rw, input logic fw,
                       input logic [4:0] rd, input logic [31:0] br,
                       input logic [31:0] np, output logic [31:0] exp_data);
    case ({o2r, m2r})
      2'b00:   exp_data = alu;
      2'b01:   exp_data = model_load(int'(alu[7:0]), f3);
      2'b10:   exp_data = br;
      default: exp_data = np;
    endcase
    if (we) model_store(int'(alu[7:0]), f3, data);
    mem_alu_result = alu; mem_data_b = data; mem_func3 = f3;
    mem_mem_write = we; mem_mem_to_reg = m2r; mem_offset_to_reg = o2r;
    mem_reg_write = rw; mem_freg_write = fw; mem_rd = rd;
    mem_branch_addr = br; mem_next_pc = np;
    step();
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({wb_data, wb_rd, wb_reg_write, wb_freg_write} !== 39'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got data=%h rd=%0d rw=%b fw=%b, want all zero",
               wb_data, wb_rd, wb_reg_write, wb_freg_write);
    end
    step();
    clear = 1'b0;
    step();
    n_cmp++;
    if (wb_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_idle_data: got %h want 00000000", wb_data);
    end
  endtask

  task automatic test_load_store();
    logic [31:0] e;
    logic [7:0]  addrs [6] = '{8'h10, 8'h10, 8'h13, 8'h10, 8'h12, 8'h13};
    logic [2:0]  f3s   [6] = '{3'd2, 3'd0, 3'd4, 3'd1, 3'd5, 3'd0};
    logic [31:0] want  [6] = '{32'h8765_4321, 32'h0000_0021, 32'h0000_0087,
                               32'h0000_4321, 32'h0000_8765, 32'hFFFF_FF87};
    do_op(32'h10, 32'h8765_4321, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 0, 0, e);
    for (int i = 0; i < 6; i++) begin
      mem_alu_result = {24'h0, addrs[i]}; mem_func3 = f3s[i];
      mem_mem_write = 1'b0; mem_mem_to_reg = 1'b1;
      #1;
      n_cmp++;
      if (wb_data === want[i]) begin
        n_err++;
        $display("FAIL load_latency_%0d: result %h visible before the clock edge", i, wb_data);
      end
      do_op({24'h0, addrs[i]}, 0, f3s[i], 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'(i+1), 0, 0, e);
      n_cmp++;
      if (wb_data !== want[i] || e !== want[i]) begin
        n_err++;
        $display("FAIL load_%0d: got %h want %h (model %h)", i, wb_data, want[i], e);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    do_op(32'hFC, 32'hDDCC_BBAA, 3'd2, 1'b1, 0, 0, 0, 0, 0, 0, 0, e);
    do_op(32'hFF, 32'h0000_0041, 3'd0, 1'b1, 0, 0, 0, 0, 0, 0, 0, e);
    do_op(32'hFC, 0, 3'd2, 1'b0, 1'b1, 0, 1, 0, 5'd3, 0, 0, e);
    n_cmp++;
    if (wb_data !== 32'h41CC_BBAA) begin
      n_err++;
      $display("FAIL sb_top_byte: got %h want 41ccbbaa", wb_data);
    end
    do_op(32'hFE, 32'h4433_2211, 3'd2, 1'b1, 0, 0, 0, 0, 0, 0, 0, e);
    do_op(32'hFE, 0, 3'd2, 1'b0, 1'b1, 0, 1, 0, 5'd3, 0, 0, e);
    n_cmp++;
    if (wb_data !== 32'h4433_2211) begin
      n_err++;
      $display("FAIL sw_wrap_read: got %h want 44332211", wb_data);
    end
    do_op(32'hFC, 0, 3'd2, 1'b0, 1'b1, 0, 1, 0, 5'd3, 0, 0, e);
    n_cmp++;
    if (wb_data !== 32'h2211_BBAA) begin
      n_err++;
      $display("FAIL sw_wrap_low_lanes: got %h want 2211bbaa", wb_data);
    end
    do_op(32'h100, 0, 3'd1, 1'b0, 1'b1, 0, 1, 0, 5'd3, 0, 0, e);
    n_cmp++;
    if (wb_data !== 32'h0000_4433) begin
      n_err++;
      $display("FAIL sw_wrap_byte0: got %h want 00004433", wb_data);
    end
  endtask

  task automatic test_wb_sel();
    logic [31:0] e;
    logic [31:0] want [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    do_op(32'h11, 32'h22, 3'd2, 1'b1, 0, 0, 0, 0, 0, 0, 0, e);
    for (int s = 0; s < 4; s++) begin
      do_op(32'h11, 0, 3'd2, 1'b0, s[0], s[1], 1'b1, 1'b1, 5'd31, 32'h33, 32'h44, e);
      n_cmp++;
      if (wb_data !== want[s] || wb_rd !== 5'd31 || !wb_reg_write || !wb_freg_write) begin
        n_err++;
        $display("FAIL wb_sel_%0d: got data=%h rd=%0d rw=%b fw=%b want data=%h rd=31 rw=1 fw=1",
                 s, wb_data, wb_rd, wb_reg_write, wb_freg_write, want[s]);
      end
    end
  endtask

  task automatic test_hazard();
    logic exp_ns;
    logic [11:0] dir [4] = '{{1'b1, 5'd5, 5'd5, 1'b0}, {1'b1, 5'd0, 5'd0, 1'b1},
                             {1'b0, 5'd5, 5'd5, 1'b1}, {1'b1, 5'd5, 5'd6, 1'b1}};
    for (int i = 0; i < 4; i++) begin
      ex_mem_read = dir[i][11]; ex_rd = dir[i][10:6]; id_rs2 = dir[i][5:1];
      id_rs1 = (i == 1) ? 5'd0 : 5'd9;
      #1;
      n_cmp++;
      if (not_stall !== dir[i][0]) begin
        n_err++;
        $display("FAIL hazard_dir_%0d: got %b want %b", i, not_stall, dir[i][0]);
      end
    end
    for (int i = 0; i < 60; i++) begin
      ex_mem_read = 1'($urandom);
      ex_rd  = 5'($urandom_range(0, 3));
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      exp_ns = 1'b1;
      if (ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2)) exp_ns = 1'b0;
      #1;
      n_cmp++;
      if (not_stall !== exp_ns) begin
        n_err++;
        $display("FAIL hazard_rand: ld=%b rd=%0d rs1=%0d rs2=%0d got %b want %b",
                 ex_mem_read, ex_rd, id_rs1, id_rs2, not_stall, exp_ns);
      end
    end
    ex_mem_read = 1'b0;
  endtask

  task automatic test_clear();
    logic [31:0] e;
    do_op(32'h80, 32'hCAFE_F00D, 3'd2, 1'b1, 0, 0, 0, 0, 0, 0, 0, e);
    do_op(32'h80, 0, 3'd2, 1'b0, 1'b1, 0, 1, 1, 5'd7, 0, 0, e);
    n_cmp++;
    if (wb_data !== 32'hCAFE_F00D || wb_rd !== 5'd7) begin
      n_err++;
      $display("FAIL clear_pre: got data=%h rd=%0d want cafef00d rd=7", wb_data, wb_rd);
    end
    mem_data_b = 32'h1234_5678; mem_mem_write = 1'b1; mem_func3 = 3'd2;
    ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4;
    #2 clear = 1'b1;
    #1;
    n_cmp++;
    if ({wb_data, wb_rd, wb_reg_write, wb_freg_write} !== 39'h0 || not_stall !== 1'b0) begin
      n_err++;
      $display("FAIL clear_async: got data=%h rd=%0d rw=%b fw=%b ns=%b want zeros ns=0",
               wb_data, wb_rd, wb_reg_write, wb_freg_write, not_stall);
    end
    step();
    n_cmp++;
    if ({wb_data, wb_rd, wb_reg_write, wb_freg_write} !== 39'h0) begin
      n_err++;
      $display("FAIL clear_hold: got data=%h rd=%0d want zeros", wb_data, wb_rd);
    end
    clear = 1'b0; ex_mem_read = 1'b0;
    do_op(32'h80, 0, 3'd2, 1'b0, 1'b1, 0, 1, 0, 5'd7, 0, 0, e);
    n_cmp++;
    if (wb_data !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL clear_ram_kept: got %h want cafef00d", wb_data);
    end
  endtask

  task automatic test_random();
    logic [31:0] e, alu, br, np, d;
    logic [2:0]  f3;
    logic        we, m2r, o2r, rw, fw;
    logic [4:0]  rd;
    for (int i = 0; i < 300; i++) begin
      alu = $urandom; d = $urandom; br = $urandom; np = $urandom;
      if (i % 3 != 0) alu[7:0] = 8'($urandom_range(0, 15)) + 8'hF8;
      f3 = 3'($urandom); we = 1'($urandom);
      m2r = 1'($urandom); o2r = 1'($urandom_range(0, 3) == 0);
      rw = 1'($urandom); fw = 1'($urandom); rd = 5'($urandom);
      do_op(alu, d, f3, we, m2r, o2r, rw, fw, rd, br, np, e);
      n_cmp++;
      if (wb_data !== e || wb_rd !== rd || wb_reg_write !== rw || wb_freg_write !== fw) begin
        n_err++;
        $display("FAIL random_%0d: got data=%h rd=%0d rw=%b fw=%b want data=%h rd=%0d rw=%b fw=%b",
                 i, wb_data, wb_rd, wb_reg_write, wb_freg_write, e, rd, rw, fw);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    test_reset();
    test_load_store();
    test_wrap();
    test_wb_sel();
    test_hazard();
    test_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
